// File: rtl/guess_pkg.sv
// rtl/guess_pkg.sv - shared types and constants for the guess round sequencer
package guess_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WAIT,
      ST_EVAL,
      ST_WIN,
      ST_LOSE
   } state_t;

   localparam int DEF_WIDTH     = 8;
   localparam int DEF_MAX_TRIES = 7;

   // Hint encoding shared with the display logic
   localparam logic [1:0] HINT_NONE = 2'b00;
   localparam logic [1:0] HINT_HI   = 2'b01;
   localparam logic [1:0] HINT_LO   = 2'b10;
   localparam logic [1:0] HINT_OUT  = 2'b11;

endpackage

// File: rtl/bound_update.sv
// rtl/bound_update.sv - combinational guess classification and next-bound computation
module bound_update #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] ll,
   input  logic [WIDTH-1:0] hl,
   input  logic [WIDTH-1:0] g,
   input  logic [WIDTH-1:0] secret,
   output logic             in_range,
   output logic             eq,
   output logic             lt,
   output logic [WIDTH-1:0] next_ll,
   output logic [WIDTH-1:0] next_hl
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   always_comb begin
      in_range = (g >= ll) && (g <= hl);
      eq       = (g == secret);
      lt       = (g < secret);
      next_ll  = ll;
      next_hl  = hl;
      if (eq) begin
         next_ll = secret;
         next_hl = secret;
      end else if (lt) begin
         // g < secret <= max, so g+1 cannot wrap
         next_ll = g + ONE;
      end else begin
         next_hl = g - ONE;
      end
   end

endmodule

// File: rtl/guess_round_ctrl.sv
// rtl/guess_round_ctrl.sv - round sequencer: secret latch, guess handshake, bounds, hints and attempt count
module guess_round_ctrl
   import guess_pkg::*;
#(
   parameter  int WIDTH     = DEF_WIDTH,
   parameter  int MAX_TRIES = DEF_MAX_TRIES,
   localparam int TRY_W     = $clog2(MAX_TRIES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] secret,
   input  logic [WIDTH-1:0] guess,
   input  logic             guess_valid,
   output logic             guess_ready,
   output logic [WIDTH-1:0] LL,
   output logic [WIDTH-1:0] HL,
   output logic             hint_hi,
   output logic             hint_lo,
   output logic             outrange,
   output logic [TRY_W-1:0] tries,
   output logic             busy,
   output logic             win,
   output logic             lose
);

   localparam logic [TRY_W-1:0] TRY_ONE = {{(TRY_W-1){1'b0}}, 1'b1};
   localparam logic [TRY_W-1:0] TRY_MAX = TRY_W'(MAX_TRIES);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] secret_r, guess_r, ll_r, hl_r;
   logic [TRY_W-1:0] tries_r;
   logic [1:0]       hint_r;

   logic             in_range, eq, lt;
   logic [WIDTH-1:0] next_ll, next_hl, g_eval;
   logic             take;

   assign take = (state == ST_WAIT) && guess_valid;

   // Classification happens on the handshake edge so the pulses are visible during EVAL
   assign g_eval = (state == ST_WAIT) ? guess : guess_r;

   bound_update #(.WIDTH(WIDTH)) u_bound_update (
      .ll       (ll_r),
      .hl       (hl_r),
      .g        (g_eval),
      .secret   (secret_r),
      .in_range (in_range),
      .eq       (eq),
      .lt       (lt),
      .next_ll  (next_ll),
      .next_hl  (next_hl)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         secret_r <= '0;
         guess_r  <= '0;
         ll_r     <= '0;
         hl_r     <= '0;
         tries_r  <= '0;
         hint_r   <= HINT_NONE;
      end else begin
         state  <= state_nxt;
         hint_r <= HINT_NONE;
         case (state)
            ST_IDLE, ST_WIN, ST_LOSE: begin
               if (start) secret_r <= secret;
            end
            ST_LOAD: begin
               ll_r    <= '0;
               hl_r    <= '1;
               tries_r <= '0;
            end
            ST_WAIT: begin
               if (take) begin
                  guess_r <= guess;
                  if (!in_range) begin
                     hint_r <= HINT_OUT;
                  end else begin
                     tries_r <= tries_r + TRY_ONE;
                     ll_r    <= next_ll;
                     hl_r    <= next_hl;
                     if (!eq) hint_r <= lt ? HINT_HI : HINT_LO;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // In EVAL, hint_r holds the verdict of the guess just taken; HINT_NONE means a hit
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_WIN, ST_LOSE: if (start) state_nxt = ST_LOAD;
         ST_LOAD: state_nxt = ST_WAIT;
         ST_WAIT: if (take) state_nxt = ST_EVAL;
         ST_EVAL: begin
            if (hint_r == HINT_OUT)       state_nxt = ST_WAIT;
            else if (hint_r == HINT_NONE) state_nxt = ST_WIN;
            else if (tries_r == TRY_MAX)  state_nxt = ST_LOSE;
            else                          state_nxt = ST_WAIT;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign guess_ready = (state == ST_WAIT);
   assign busy        = (state == ST_LOAD) || (state == ST_WAIT) || (state == ST_EVAL);
   assign win         = (state == ST_WIN);
   assign lose        = (state == ST_LOSE);
   assign hint_hi     = (hint_r == HINT_HI);
   assign hint_lo     = (hint_r == HINT_LO);
   assign outrange    = (hint_r == HINT_OUT);
   assign LL          = ll_r;
   assign HL          = hl_r;
   assign tries       = tries_r;

endmodule
